// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding and default frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_data_bits_dflt  = 8;
    localparam int c_oversample_dflt = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchronizer for a single async input, settable reset level.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : Oversampling UART receiver front end with stop-bit sample/strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_data_bits_dflt,
    parameter int OVERSAMPLE = c_oversample_dflt,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 rx_bit_sample,
    output logic                 chk_stop,
    output logic                 busy
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);

    localparam logic [c_tick_w-1:0] c_half_last = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_full_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
    localparam logic                c_par_inv   = (PARITY_ODD != 0);

    logic                 w_rxs;
    uart_state_t          w_after_data;
    logic [c_tick_w-1:0]  w_tick_last;
    logic                 w_in_frame;
    logic                 w_tick_hit;

    uart_state_t          r_state;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_error;
    logic                 r_rx_bit_sample;
    logic                 r_chk_stop;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_in),
        .q       (w_rxs)
    );

    if (PARITY_EN != 0) begin : g_parity
        assign w_after_data = ST_PARITY;
    end else begin : g_no_parity
        assign w_after_data = ST_STOP;
    end

    // START waits half a bit to land mid-bit; later bits sample one full bit apart.
    assign w_tick_last = (r_state == ST_START) ? c_half_last : c_full_last;
    assign w_in_frame  = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_tick_hit  = baud_tick && w_in_frame && (r_tick_cnt == w_tick_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_tick_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_perr          <= 1'b0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_parity_error  <= 1'b0;
            r_rx_bit_sample <= 1'b1;
            r_chk_stop      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_chk_stop <= 1'b0;

            if (baud_tick && w_in_frame) begin
                r_tick_cnt <= w_tick_hit ? '0 : r_tick_cnt + c_tick_one;
            end

            case (r_state)
                ST_IDLE: begin
                    if (baud_tick && !w_rxs) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick_hit) begin
                        if (!w_rxs) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_perr    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick_hit) begin
                        r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + c_bit_one;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= w_after_data;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick_hit) begin
                        r_perr  <= (w_rxs != ((^r_shift) ^ c_par_inv));
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Level is committed a clock ahead of the strobe so the checker sees it settled.
                    if (w_tick_hit) begin
                        r_rx_bit_sample <= w_rxs;
                        r_state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_chk_stop     <= 1'b1;
                    r_rx_valid     <= 1'b1;
                    r_rx_data      <= r_shift;
                    r_parity_error <= r_perr;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign parity_error  = r_parity_error;
    assign rx_bit_sample = r_rx_bit_sample;
    assign chk_stop      = r_chk_stop;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sampler
// Brief    : Scoreboard bench: 8N1 instance and 8E1 instance of uart_rx_sampler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sampler;

    localparam int c_os       = 16;
    localparam int c_tick_div = 4;
    localparam int c_bit_clk  = c_os * c_tick_div;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       stop;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       parity_error0, parity_error1;
    logic       rx_bit_sample0, rx_bit_sample1;
    logic       chk_stop0, chk_stop1;
    logic       busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_rx_sampler #(
        .DATA_BITS(8), .OVERSAMPLE(c_os), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx_in(rx0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .parity_error(parity_error0),
        .rx_bit_sample(rx_bit_sample0), .chk_stop(chk_stop0), .busy(busy0)
    );

    uart_rx_sampler #(
        .DATA_BITS(8), .OVERSAMPLE(c_os), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx_in(rx1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .parity_error(parity_error1),
        .rx_bit_sample(rx_bit_sample1), .chk_stop(chk_stop1), .busy(busy1)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (c_tick_div - 1) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int sel, input logic lvl, input int nclk);
        if (sel == 0) rx0 = lvl;
        else          rx1 = lvl;
        repeat (nclk) @(negedge clk);
    endtask

    // Reference: data LSB first, even parity bit must equal popcount(data) mod 2.
    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic par_bit, input logic stop_lvl);
        exp_t e;
        e.data = data;
        e.stop = stop_lvl;
        e.perr = (sel == 1) ? (par_bit != (($countones(data) % 2) == 1)) : 1'b0;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        drive(sel, 1'b0, c_bit_clk);
        for (int i = 0; i < 8; i++) drive(sel, data[i], c_bit_clk);
        if (sel == 1) drive(sel, par_bit, c_bit_clk);
        drive(sel, stop_lvl, c_bit_clk);
        if (sel == 0) rx0 = 1'b1;
        else          rx1 = 1'b1;
    endtask

    task automatic monitor(input int sel);
        logic       prev_bs;
        logic       prev_v;
        logic       v, cs, bs, pe;
        logic [7:0] d;
        exp_t       e;
        int         qn;
        prev_bs = 1'b1;
        prev_v  = 1'b0;
        forever begin
            @(negedge clk);
            v  = (sel == 0) ? rx_valid0      : rx_valid1;
            cs = (sel == 0) ? chk_stop0      : chk_stop1;
            bs = (sel == 0) ? rx_bit_sample0 : rx_bit_sample1;
            pe = (sel == 0) ? parity_error0  : parity_error1;
            d  = (sel == 0) ? rx_data0       : rx_data1;
            if (!reset_n) begin
                prev_bs = 1'b1;
                prev_v  = 1'b0;
            end else begin
                if (cs != v) check($sformatf("strobe_pair%0d", sel), {31'd0, cs}, {31'd0, v});
                if (v) begin
                    qn = (sel == 0) ? q0.size() : q1.size();
                    if (qn == 0) begin
                        check($sformatf("unexpected_valid%0d", sel), 32'd1, 32'd0);
                    end else begin
                        if (sel == 0) e = q0.pop_front();
                        else          e = q1.pop_front();
                        check($sformatf("rx_data%0d", sel), {24'd0, d}, {24'd0, e.data});
                        check($sformatf("parity_error%0d", sel), {31'd0, pe}, {31'd0, e.perr});
                        check($sformatf("stop_sample%0d", sel), {31'd0, bs}, {31'd0, e.stop});
                        check($sformatf("stop_presettled%0d", sel), {31'd0, prev_bs}, {31'd0, e.stop});
                        check($sformatf("strobe_gap%0d", sel), {31'd0, prev_v}, 32'd0);
                    end
                end
                prev_bs = bs;
                prev_v  = v;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_rx_data",      {24'd0, rx_data0}, 32'd0);
        check("rst_rx_valid",     {31'd0, rx_valid0}, 32'd0);
        check("rst_parity_error", {31'd0, parity_error1}, 32'd0);
        check("rst_bit_sample",   {31'd0, rx_bit_sample0}, 32'd1);
        check("rst_chk_stop",     {31'd0, chk_stop0}, 32'd0);
        check("rst_busy",         {31'd0, busy0}, 32'd0);
        reset_n = 1'b1;
        repeat (2 * c_bit_clk) @(negedge clk);

        send_frame(0, 8'hA5, 1'b0, 1'b1);
        drive(0, 1'b1, 2 * c_bit_clk);
        check("hold_rx_data", {24'd0, rx_data0}, 32'h0000_00A5);

        // Five-tick low pulse must be rejected as a false start.
        drive(0, 1'b0, 5 * c_tick_div);
        check("glitch_busy_hi", {31'd0, busy0}, 32'd1);
        drive(0, 1'b1, 10 * c_tick_div);
        check("glitch_busy_lo", {31'd0, busy0}, 32'd0);
        drive(0, 1'b1, c_bit_clk);

        send_frame(0, 8'h3C, 1'b0, 1'b0);
        drive(0, 1'b1, 2 * c_bit_clk);

        send_frame(0, 8'h55, 1'b0, 1'b1);
        send_frame(0, 8'hAA, 1'b0, 1'b1);
        drive(0, 1'b1, 2 * c_bit_clk);

        send_frame(1, 8'h07, 1'b1, 1'b1);
        drive(1, 1'b1, c_bit_clk);
        send_frame(1, 8'h07, 1'b0, 1'b1);
        drive(1, 1'b1, c_bit_clk);

        for (int i = 0; i < 10; i++) begin
            send_frame(1, 8'($urandom), 1'($urandom), 1'b1);
            drive(1, 1'b1, int'($urandom_range(0, 40)));
        end
        for (int i = 0; i < 12; i++) begin
            send_frame(0, 8'($urandom), 1'b0, 1'b1);
            drive(0, 1'b1, int'($urandom_range(0, 40)));
        end
        drive(0, 1'b1, 2 * c_bit_clk);

        // Reset in the middle of data bit 4 of 0xFF; partial frame must vanish.
        drive(0, 1'b0, c_bit_clk);
        drive(0, 1'b1, 4 * c_bit_clk + c_bit_clk / 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rx_data",    {24'd0, rx_data0}, 32'd0);
        check("mid_rst_rx_valid",   {31'd0, rx_valid0}, 32'd0);
        check("mid_rst_bit_sample", {31'd0, rx_bit_sample0}, 32'd1);
        check("mid_rst_chk_stop",   {31'd0, chk_stop0}, 32'd0);
        check("mid_rst_busy",       {31'd0, busy0}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1'b1, 2 * c_bit_clk);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        drive(0, 1'b1, 2 * c_bit_clk);
        check("post_rst_rx_data", {24'd0, rx_data0}, 32'h0000_0012);

        for (int i = 0; i < 2000 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("drain_q0", q0.size(), 32'd0);
        check("drain_q1", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
